alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle RV32I-style ALU: single-cycle base ops plus iterative unsigned MUL/MULHU/DIVU/REMU.
// Optional build macro ALU_SEQ_FLAGS_EN adds registered zero/negative outputs.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [3:0]       aluControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             zero,
  output logic             negative,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               res_ld;

  logic [WIDTH-1:0]   alu_res;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_trial, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_nx, quo_nx;
  logic               last_iter;

  assign shamt = operandB[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (aluControl)
      4'b0000: alu_res = operandA + operandB;
      4'b0001: alu_res = operandA - operandB;
      4'b0010: alu_res = operandA & operandB;
      4'b0011: alu_res = operandA | operandB;
      4'b0100: alu_res = operandA ^ operandB;
      4'b0101: alu_res = operandA << shamt;
      4'b0110: alu_res = operandA >> shamt;
      4'b0111: alu_res = WIDTH'($signed(operandA) >>> shamt);
      4'b1000: alu_res = {{(WIDTH-1){1'b0}}, $signed(operandA) < $signed(operandB)};
      4'b1001: alu_res = {{(WIDTH-1){1'b0}}, operandA < operandB};
      default: alu_res = '0;
    endcase
  end

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, b_q} : '0);
  assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};

  // Restoring divide; a zero divisor naturally yields all-ones quotient and remainder = dividend.
  assign div_trial = {rem_q, quo_q[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, b_q};
  assign div_diff  = div_trial - {1'b0, b_q};
  assign rem_nx    = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign quo_nx    = {quo_q[WIDTH-2:0], div_ge};

  assign last_iter = (cnt_q == SHW'(WIDTH-1));

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    op_d     = op_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    res_ld   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = aluControl;
          b_d   = operandB;
          cnt_d = '0;
          if (aluControl == OP_MUL || aluControl == OP_MULHU) begin
            prod_d  = {{WIDTH{1'b0}}, operandA};
            state_d = S_MUL;
          end else if (aluControl == OP_DIVU || aluControl == OP_REMU) begin
            quo_d   = operandA;
            rem_d   = '0;
            state_d = S_DIV;
          end else begin
            result_d = alu_res;
            res_ld   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        prod_d = mul_step;
        cnt_d  = cnt_q + SHW'(1);
        if (last_iter) begin
          result_d = (op_q == OP_MULHU) ? mul_step[2*WIDTH-1:WIDTH] : mul_step[WIDTH-1:0];
          res_ld   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + SHW'(1);
        if (last_iter) begin
          result_d = (op_q == OP_REMU) ? rem_nx : quo_nx;
          res_ld   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      op_q     <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      op_q     <= op_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign result    = result_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q, neg_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (res_ld) begin
      zero_q <= (result_d == '0);
      neg_q  <= result_d[WIDTH-1];
    end
  end
  assign zero     = zero_q;
  assign negative = neg_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq: base ops, iterative mul/div, backpressure, mid-op reset.
module tb_alu_seq;
  localparam int W = 32;

  logic         clk, rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] operandA, operandB;
  logic [3:0]   aluControl;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         busy;
`ifdef ALU_SEQ_FLAGS_EN
  logic         zero, negative;
`endif

  int tests = 0;
  int fails = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .operandA(operandA), .operandB(operandB), .aluControl(aluControl),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
`ifdef ALU_SEQ_FLAGS_EN
    .zero(zero), .negative(negative),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called and returns at 1 time unit after a rising edge.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat, output int busyc,
                        output logic rdy_at_done);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    aluControl = op; operandA = a; operandB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    operandA = '1; operandB = '1; aluControl = 4'b0001;
    lat = 1; busyc = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busyc++;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    rdy_at_done = in_ready;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    operandA = '0; operandB = '0; aluControl = '0;
    #3;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (result !== '0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [3:0]   ops [12] = '{4'b0000, 4'b0001, 4'b0111, 4'b1000, 4'b1001, 4'b0101,
                               4'b0010, 4'b0011, 4'b0100, 4'b0110, 4'b1110, 4'b0001};
    logic [W-1:0] as  [12] = '{32'h1, 32'h2, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,
                               32'hF0F0_1234, 32'hF0F0_0000, 32'hFFFF_0000, 32'h8000_0000, 32'h1234, 32'h0};
    logic [W-1:0] bs  [12] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h21,
                               32'h0FF0_FF00, 32'h0000_00FF, 32'h0FF0_0FF0, 32'h4, 32'h5678, 32'h1};
    logic [W-1:0] exp [12] = '{32'h2, 32'h1, 32'hC000_0000, 32'h1, 32'h0, 32'h2,
                               32'h00F0_1200, 32'hF0F0_00FF, 32'hF00F_0FF0, 32'h0800_0000, 32'h0, 32'hFFFF_FFFF};
    logic [W-1:0] r; int lat, bc; logic rdy;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, bc, rdy);
      tests++; if (r !== exp[i]) begin fails++; $display("FAIL single_result[%0d] got %h want %h", i, r, exp[i]); end
      tests++; if (lat !== 1) begin fails++; $display("FAIL single_latency[%0d] got %0d want 1", i, lat); end
      tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL single_in_ready[%0d] got %b want 0", i, rdy); end
`ifdef ALU_SEQ_FLAGS_EN
      tests++; if ({zero, negative} !== {exp[i] == '0, exp[i][W-1]}) begin
        fails++; $display("FAIL single_flags[%0d] got %b%b", i, zero, negative); end
`endif
    end
  endtask

  task automatic test_iterative();
    logic [3:0]   ops [7] = '{4'b1010, 4'b1011, 4'b1010, 4'b1100, 4'b1101, 4'b1100, 4'b1101};
    logic [W-1:0] as  [7] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd5, 32'd5};
    logic [W-1:0] bs  [7] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [W-1:0] exp [7] = '{32'd42, 32'hFFFF_FFFE, 32'h1, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
    logic [W-1:0] r; int lat, bc; logic rdy;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, bc, rdy);
      tests++; if (r !== exp[i]) begin fails++; $display("FAIL iter_result[%0d] got %h want %h", i, r, exp[i]); end
      tests++; if (lat !== W + 1) begin fails++; $display("FAIL iter_latency[%0d] got %0d want %0d", i, lat, W + 1); end
      tests++; if (bc !== W) begin fails++; $display("FAIL iter_busy_cycles[%0d] got %0d want %0d", i, bc, W); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r; int lat, bc; logic rdy;
    out_ready = 1'b0;
    run_op(4'b1010, 32'd3, 32'd5, r, lat, bc, rdy);
    tests++; if (r !== 32'd15) begin fails++; $display("FAIL bp_result got %h want f", r); end
    in_valid = 1'b1; aluControl = 4'b0000; operandA = 32'd1; operandB = 32'd1;
    for (int c = 0; c < 5; c++) begin
      tests++; if ({out_valid, in_ready} !== 2'b10 || result !== 32'd15) begin
        fails++; $display("FAIL bp_hold[%0d] got ov=%b ir=%b res=%h want ov=1 ir=0 res=f", c, out_valid, in_ready, result); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
    run_op(4'b0000, 32'd10, 32'd20, r, lat, bc, rdy);
    tests++; if (r !== 32'd30 || lat !== 1) begin
      fails++; $display("FAIL bp_next_op got %h lat %0d want 1e lat 1", r, lat); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r; int lat, bc; logic rdy;
    aluControl = 4'b1100; operandA = 32'd1000; operandB = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    tests++; if ({out_valid, busy, in_ready} !== 3'b001 || result !== '0) begin
      fails++; $display("FAIL mid_reset got ov=%b busy=%b ir=%b res=%h want 0 0 1 0", out_valid, busy, in_ready, result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(4'b0000, 32'd3, 32'd4, r, lat, bc, rdy);
    tests++; if (r !== 32'd7) begin fails++; $display("FAIL mid_after_add got %h want 7", r); end
    tests++; if (lat !== 1) begin fails++; $display("FAIL mid_after_lat got %0d want 1", lat); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_iterative();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
